ps2_mouse_init_ctrl: RTL
========================

// Module: ps2_mouse_init_ctrl
// PURPOSE
//  Brings a PS/2 mouse from power-up into stream mode, then frames its 3-byte movement packets.
//  Init sequence: send Reset 0xFF; expect ACK 0xFA, BAT-pass 0xAA, ID 0x00; send Enable 0xF4; expect 0xFA.
//  Sits between the PS/2 byte-level rx/tx serdes and the pointer logic.
//  Includes a per-step response timeout and a bounded retry count.
// PARAMETERS
//  TIMEOUT_CYCLES  1000000  cycles allowed in any wait-for-response state before failure (>=2)
//  MAX_RETRIES     2        failed attempts retried before giving up (attempts = MAX_RETRIES+1)
// PORTS
//  clk        in   1   clock
//  reset      in   1   reset: synchronous, active-high
//  restart    in   1   1-cycle pulse: abort everything and rerun init from scratch
//  rx_valid   in   1   rx_data holds one received byte this cycle
//  rx_data    in   8   received byte
//  tx_valid   out  1   command byte offered to the tx serdes
//  tx_data    out  8   command byte
//  tx_ready   in   1   serdes accepts tx_data when tx_valid && tx_ready
//  ready      out  1   init complete; packet framing active
//  error      out  1   init failed after all retries (sticky)
//  pkt_valid  out  1   1-cycle pulse: pkt_data holds a complete packet
//  pkt_data   out  24  {byte1, byte2, byte3}; byte1 is in [23:16]
// BEHAVIOUR
//  States: IDLE, SEND_RST, W_ACK1, W_BAT, W_ID, SEND_EN, W_ACK2, STR_B1, STR_B2, STR_B3, FAIL.
//  Reset: state=IDLE; retry_cnt=0; timer=0. All outputs 0; pkt_data=0.
//  IDLE -> SEND_RST unconditionally on the next clock.
//  Command send states:
//   - tx_valid=1 combinationally in SEND_RST/SEND_EN only. tx_data=0xFF/0xF4 there, else 0x00.
//   - Offer is held stable until the handshake. SEND_RST->W_ACK1 and SEND_EN->W_ACK2 on tx_valid&&tx_ready.
//   - rx bytes arriving in send states are dropped.
//  Wait states (W_ACK1 0xFA, W_BAT 0xAA, W_ID 0x00, W_ACK2 0xFA):
//   - timer clears on state entry and increments every cycle spent in the state.
//   - Matching rx byte: W_ACK1->W_BAT->W_ID->SEND_EN; W_ACK2->STR_B1.
//   - Failure is either (a) an rx byte that does not match (incl. 0xFE, 0xFC), or
//     (b) timer==TIMEOUT_CYCLES-1 with no matching byte that cycle.
//   - A matching byte in the timeout cycle wins: it advances, no failure.
//  On failure: if retry_cnt==MAX_RETRIES -> FAIL; else retry_cnt++ and -> SEND_RST.
//  FAIL: error=1, tx_valid=0, all rx ignored. Exits only via reset or restart.
//  Streaming (ready=1 in STR_B1..B3); no timeout.
//   - STR_B1: byte with rx_data[3]=1 is stored as byte1 -> STR_B2; bit3=0 is discarded (resync).
//   - STR_B2: any byte is stored as byte2 -> STR_B3.
//   - STR_B3: any byte -> STR_B1. On the next clock: pkt_valid=1 for one cycle; pkt_data={b1,b2,b3}.
//   - Back-to-back: bytes on consecutive cycles are legal; consecutive packets lose no bytes.
//   - pkt_data holds its value until the next packet.
//  restart (any state, incl. FAIL): next state SEND_RST; retry_cnt=0; timer=0; error=0.
//   - A partial packet is dropped and the pending pkt_valid is suppressed.
//   - restart takes priority over any simultaneous rx byte or tx handshake.
//  reset has priority over restart.
// TESTING (TIMEOUT_CYCLES=16, MAX_RETRIES=2)
//  1. Happy path, tx_ready=1: accept 0xFF; feed 0xFA,0xAA,0x00; accept 0xF4; feed 0xFA.
//     -> ready=1 the cycle after the final 0xFA; error=0.
//  2. Streaming after init: feed 0x00 then 0x08,0x12,0x34,0x09,0x56,0x78 on consecutive cycles.
//     -> 0x00 discarded; pkt_valid pulses with 0x081234, then 0x095678; no other pkt_valid.
//  3. Backpressure: tx_ready=0 for 5 cycles after reset.
//     -> tx_valid=1, tx_data=0xFF held all 5 cycles; one handshake when tx_ready rises.
//  4. Silent device: no rx. -> tx_valid re-asserts 0xFF 16 cycles after each handshake.
//     After the 3rd timeout: error=1, tx_valid=0, ready=0.
//  5. Mismatch: reply 0xFE in W_ACK1. -> next cycle tx_valid=1, tx_data=0xFF (retry).
//     0xFA arriving in the 16th wait cycle advances to W_BAT.
//  6. restart mid-stream after bytes 0x08,0x12. -> ready=0, tx_data=0xFF offered.
//     No pkt_valid; error clears when restart is issued from FAIL.

Source files
------------

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse bring-up controller: resets the mouse, enables streaming mode,
// then frames the 3-byte movement packets for the pointer logic.
module ps2_mouse_init_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        ready,
  output logic        error,
  output logic        pkt_valid,
  output logic [23:0] pkt_data
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 2);

  typedef enum logic [3:0] {
    IDLE, SEND_RST, W_ACK1, W_BAT, W_ID, SEND_EN, W_ACK2,
    STR_B1, STR_B2, STR_B3, FAIL
  } state_t;

  state_t        state, state_n, adv_state;
  logic [TW-1:0] timer, timer_n;
  logic [RW-1:0] retry_cnt, retry_n;
  logic [7:0]    exp_byte;
  logic          in_wait;
  logic [7:0]    b1, b2;

  // Next-state, retry/timer bookkeeping and command offer.
  always_comb begin
    state_n   = state;
    retry_n   = retry_cnt;
    timer_n   = '0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    exp_byte  = '0;
    adv_state = state;
    in_wait   = 1'b0;
    case (state)
      IDLE:     state_n = SEND_RST;
      SEND_RST: begin
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        if (tx_ready) state_n = W_ACK1;
      end
      SEND_EN: begin
        tx_valid = 1'b1;
        tx_data  = 8'hF4;
        if (tx_ready) state_n = W_ACK2;
      end
      W_ACK1: begin in_wait = 1'b1; exp_byte = 8'hFA; adv_state = W_BAT;   end
      W_BAT:  begin in_wait = 1'b1; exp_byte = 8'hAA; adv_state = W_ID;    end
      W_ID:   begin in_wait = 1'b1; exp_byte = 8'h00; adv_state = SEND_EN; end
      W_ACK2: begin in_wait = 1'b1; exp_byte = 8'hFA; adv_state = STR_B1;  end
      STR_B1: if (rx_valid && rx_data[3]) state_n = STR_B2;
      STR_B2: if (rx_valid) state_n = STR_B3;
      STR_B3: if (rx_valid) state_n = STR_B1;
      FAIL:   state_n = FAIL;
      default: state_n = IDLE;
    endcase

    // Shared wait-state handling: a matching byte beats a same-cycle timeout.
    if (in_wait) begin
      if (rx_valid && rx_data == exp_byte) begin
        state_n = adv_state;
      end else if (rx_valid || timer == TW'(TIMEOUT_CYCLES - 1)) begin
        if (retry_cnt == RW'(MAX_RETRIES)) begin
          state_n = FAIL;
        end else begin
          retry_n = retry_cnt + RW'(1);
          state_n = SEND_RST;
        end
      end
      timer_n = (state_n == state) ? timer + TW'(1) : '0;
    end

    if (restart) begin
      state_n = SEND_RST;
      retry_n = '0;
      timer_n = '0;
    end
  end

  // Status flags decoded from the current state.
  always_comb begin
    ready = (state == STR_B1) || (state == STR_B2) || (state == STR_B3);
    error = (state == FAIL);
  end

  // State registers and packet assembly; restart drops any partial packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      retry_cnt <= '0;
      b1        <= '0;
      b2        <= '0;
      pkt_valid <= 1'b0;
      pkt_data  <= '0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      retry_cnt <= retry_n;
      pkt_valid <= 1'b0;
      if (!restart && rx_valid) begin
        case (state)
          STR_B1: if (rx_data[3]) b1 <= rx_data;
          STR_B2: b2 <= rx_data;
          STR_B3: begin
            pkt_valid <= 1'b1;
            pkt_data  <= {b1, b2, rx_data};
          end
          default: ;
        endcase
      end
    end
  end

endmodule
